// File: rtl/imem_uart_loader.sv
// ============================================================================
//  Module   : imem_uart_loader
//  Purpose  : UART boot loader; receives a length-prefixed little-endian image
//             and writes it into instruction memory while holding the core in reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imem_uart_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset_n,
   output logic              load_done,
   output logic              frame_err,
   output logic              ovf
);

   localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]      C_DEPTH     = 17'(1) << ADDR_W;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE} ld_state_t;

   // ---------------- RX front end ----------------
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q, frame_err_d;

   // Synchronizer idles high so reset release never looks like a start edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= uart_rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_state_q   <= rx_state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = frame_err_q;
      case (rx_state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == C_HALF_LAST) begin
               cnt_d      = '0;
               bit_idx_d  = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == C_BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == C_BIT_LAST) begin
               cnt_d      = '0;
               rx_state_d = RX_IDLE;
               if (rx_sync_q) byte_valid_d = 1'b1;
               else           frame_err_d  = 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- Loader ----------------
   ld_state_t         ld_state_q, ld_state_d;
   logic [15:0]       count_q, count_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [15:0]       word_idx_q, word_idx_d;
   logic [23:0]       word_q, word_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ld_state_q <= LD_LEN_LO;
         count_q    <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         word_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         ld_state_q <= ld_state_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         last_q     <= last_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   // last_q marks the final word even when its write was suppressed, so an
   // overflowing image still completes one cycle after its last word.
   always_comb begin
      ld_state_d = ld_state_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      word_d     = word_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      last_d     = 1'b0;
      done_d     = done_q | last_q;
      ovf_d      = ovf_q;
      case (ld_state_q)
         LD_LEN_LO: begin
            if (byte_valid_q) begin
               count_d[7:0] = shift_q;
               ld_state_d   = LD_LEN_HI;
            end
         end
         LD_LEN_HI: begin
            if (byte_valid_q) begin
               count_d[15:8] = shift_q;
               byte_idx_d    = '0;
               word_idx_d    = '0;
               if ({shift_q, count_q[7:0]} == 16'd0) begin
                  ld_state_d = LD_DONE;
                  done_d     = 1'b1;
               end else begin
                  ld_state_d = LD_DATA;
               end
            end
         end
         LD_DATA: begin
            if (byte_valid_q) begin
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = shift_q;
                  2'd1: word_d[15:8]  = shift_q;
                  2'd2: word_d[23:16] = shift_q;
                  default: begin
                     word_idx_d = word_idx_q + 16'd1;
                     if ({1'b0, word_idx_q} < C_DEPTH) begin
                        we_d    = 1'b1;
                        waddr_d = word_idx_q[ADDR_W-1:0];
                        wdata_d = {shift_q, word_q};
                     end else begin
                        ovf_d = 1'b1;
                     end
                     if (word_idx_q == count_q - 16'd1) begin
                        ld_state_d = LD_DONE;
                        last_d     = 1'b1;
                     end
                  end
               endcase
            end
         end
         default: ld_state_d = LD_DONE;
      endcase
   end

   assign imem_we     = we_q;
   assign imem_waddr  = waddr_q;
   assign imem_wdata  = wdata_q;
   assign load_done   = done_q;
   assign cpu_reset_n = done_q;
   assign frame_err   = frame_err_q;
   assign ovf         = ovf_q;

endmodule

`default_nettype wire
